// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner with frame-synchronous double-buffered
// display data and optional leading-zero blanking. All outputs are registered.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_data,
  input  logic        seg_we,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg_out,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   pend_q, pend_d;
  logic [31:0]   disp_q, disp_d;
  logic          pv_q, pv_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          tc, boundary, blank;
  logic [3:0]    nib;
  logic [7:0]    zero_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // zero_hi[k]: nibble k and every nibble above it are zero
  always_comb begin
    zero_hi    = '0;
    zero_hi[7] = (disp_q[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--)
      zero_hi[k] = zero_hi[k+1] && (disp_q[4*k +: 4] == 4'h0);
  end

  always_comb begin
    tc       = (presc_q == PRESC_MAX);
    boundary = tc && (idx_q == 3'd7);
    presc_d  = tc ? '0 : presc_q + PW'(1);
    idx_d    = tc ? idx_q + 3'd1 : idx_q;

    pend_d = seg_we ? seg_data : pend_q;
    disp_d = disp_q;
    pv_d   = seg_we ? 1'b1 : pv_q;
    // A write landing on the boundary goes straight to the display, nothing left pending
    if (boundary) begin
      pv_d = 1'b0;
      if (seg_we)    disp_d = seg_data;
      else if (pv_q) disp_d = pend_q;
    end

    nib   = disp_q[{idx_q, 2'b00} +: 4];
    blank = blank_lz && (idx_q != 3'd0) && zero_hi[idx_q];
    an_d  = ~(8'd1 << idx_q);
    seg_d = blank ? 7'h7F : hex7(nib);
    dp_d  = ~dp_mask[idx_q];
    fd_d  = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      pv_q    <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      pv_q    <= pv_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg_out    = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (SCAN_DIV=4): stimulus queues per-cycle expected
// outputs; a negedge monitor pops and compares them as the cycles go by.
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic [31:0] seg_data;
  logic        seg_we;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg_out;
  logic        dp;
  logic        frame_done;

  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .seg_data(seg_data), .seg_we(seg_we),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .an(an), .seg_out(seg_out),
    .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  // cyc = number of rising edges so far; outputs at a negedge reflect edge number cyc
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int unsigned c, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h", nm, c, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_cycle cyc %0d got %0d want %0d", e.cyc, cyc, e.cyc);
      end else begin
        chk("an",         e.cyc, an,                e.an);
        chk("seg_out",    e.cyc, {1'b0, seg_out},   {1'b0, e.seg});
        chk("dp",         e.cyc, {7'd0, dp},        {7'd0, e.dp});
        chk("frame_done", e.cyc, {7'd0, frame_done}, {7'd0, e.fd});
      end
    end
  end

  task automatic expect_off(input int unsigned c);
    exp_t e;
    e.cyc = c; e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
    q.push_back(e);
  endtask

  // codes[d] = expected seg_out for digit d; each digit held 4 cycles
  task automatic expect_frame(input int unsigned base, input logic [7:0][6:0] codes,
                              input logic [7:0] dpm, input int n);
    exp_t e;
    int   d;
    for (int j = 0; j < n; j++) begin
      d     = j / 4;
      e.cyc = base + j;
      e.an  = ~(8'd1 << d);
      e.seg = codes[d[2:0]];
      e.dp  = ~dpm[d[2:0]];
      e.fd  = (j == 31);
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write(input int unsigned c, input logic [31:0] v);
    wait_cyc(c);
    seg_data = v;
    seg_we   = 1'b1;
    wait_cyc(c + 1);
    seg_we   = 1'b0;
  endtask

  localparam logic [55:0] ZERO   = {8{7'h40}};
  localparam logic [55:0] ABCD   = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [55:0] TWOS   = {8{7'h24}};
  localparam logic [55:0] F5_BLK = {{6{7'h7F}}, 7'h0E, 7'h12};
  localparam logic [55:0] F5_RAW = {{6{7'h40}}, 7'h0E, 7'h12};

  initial begin : stim
    int guard;
    rst      = 1'b1;
    seg_data = '0;
    seg_we   = 1'b0;
    dp_mask  = 8'h00;
    blank_lz = 1'b0;

    // Release at negedge 3 -> first scanning edge is 4; frame n outputs at 4+32n..
    for (int c = 1; c <= 3; c++) expect_off(c);
    expect_frame(4,   ZERO,   8'h00, 32);
    expect_frame(36,  ZERO,   8'h00, 32);
    expect_frame(68,  ABCD,   8'h00, 32);
    expect_frame(100, TWOS,   8'h00, 32);
    expect_frame(132, F5_BLK, 8'h04, 32);
    expect_frame(164, F5_RAW, 8'h00, 32);
    expect_frame(196, F5_RAW, 8'h00, 20);
    for (int c = 216; c <= 218; c++) expect_off(c);
    expect_frame(219, ZERO,   8'h00, 32);
    expect_frame(251, ZERO,   8'h00, 32);

    wait_cyc(3);
    rst = 1'b0;
    write(46, 32'h0123_ABCD);            // mid-frame 1, shown from frame 2
    write(73, 32'h1111_1111);            // overwritten before the boundary
    write(88, 32'h2222_2222);
    write(130, 32'h0000_00F5);           // sampled on the boundary edge 131
    wait_cyc(131);
    blank_lz = 1'b1;
    dp_mask  = 8'h04;
    wait_cyc(163);
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    write(201, 32'hFFFF_FFFF);           // left pending, then wiped by reset
    wait_cyc(215);
    rst = 1'b1;                          // edge 216 sees index 5
    write(216, 32'hAAAA_AAAA);           // discarded: reset wins
    wait_cyc(218);
    rst = 1'b0;

    guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout got %0d want 0 pending expectations", q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
